// File: rtl/lut_layer_pkg.sv
// Shared types and sizing helpers for the LUT neuron layer.
// Optional feature macro used by this slice: LUT_PARITY_EN (stores an even-parity bit per entry).
package lut_layer_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Sizing for the default configuration (4 neurons, 8 address bits each).
  localparam int NEURONS_DEF = 4;
  localparam int IN_BITS_DEF = 8;
  localparam int DEPTH       = 2 ** IN_BITS_DEF;
  localparam int TOTAL_WORDS = NEURONS_DEF * DEPTH;

  // Width of the load address counter that walks every entry of every neuron.
  function automatic int addr_w(input int total_words = TOTAL_WORDS);
    return (total_words > 1) ? $clog2(total_words) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron's truth table: single write port, single asynchronous read port.
// Contents are never reset; the table is only meaningful after a full load.
module lut_neuron_ram
  import lut_layer_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int NUM_ENTRIES = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [NUM_ENTRIES];

  // Synchronous write of one table entry during a load.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_layer.sv
// Layer of NEURONS parallel LUT neurons with a runtime-loadable table,
// 2-stage valid/ready pipeline and a serial configuration port.
// Optional feature macro: LUT_PARITY_EN (per-entry even parity with sticky err).
module lut_neuron_layer
  import lut_layer_pkg::*;
#(
  parameter int NEURONS  = 4,
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NEURONS*IN_BITS-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data,
  input  logic                         cfg_start,
  input  logic                         cfg_valid,
  input  logic [OUT_BITS-1:0]          cfg_data,
  input  logic                         cfg_par,
  output logic                         cfg_done,
  output logic                         err
);

  localparam int NUM_ENTRIES = 1 << IN_BITS;
  localparam int NUM_WORDS   = NEURONS * NUM_ENTRIES;
  localparam int AW          = addr_w(NUM_WORDS);
`ifdef LUT_PARITY_EN
  localparam int RAM_W       = OUT_BITS + 1;
`else
  localparam int RAM_W       = OUT_BITS;
`endif
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

  state_e                        state_q, state_d;
  logic [AW-1:0]                 load_addr_q, load_addr_d;
  logic                          cfg_done_q, cfg_done_d;
  logic                          err_q, err_d;
  logic                          s1_v_q, s1_v_d;
  logic [NEURONS*IN_BITS-1:0]    s1_data_q, s1_data_d;
  logic                          s2_v_q, s2_v_d;
  logic [NEURONS*OUT_BITS-1:0]   s2_data_q, s2_data_d;

  logic                          load_we;
  logic [NEURONS-1:0]            ram_we;
  logic [RAM_W-1:0]              ram_wdata;
  logic [NEURONS*RAM_W-1:0]      ram_rdata;
  logic [NEURONS*OUT_BITS-1:0]   s2_next;
  logic                          s2_load;
  logic                          in_fire;

`ifdef LUT_PARITY_EN
  logic [NEURONS-1:0]            par_bad;
  assign ram_wdata = {cfg_par, cfg_data};
`else
  logic                          unused_cfg_par;
  assign unused_cfg_par = cfg_par;
  assign ram_wdata      = cfg_data;
`endif

  // s1 hands over to s2 whenever s2 is empty or its word leaves this cycle.
  assign s2_load  = s1_v_q && (!s2_v_q || out_ready);
  assign in_ready = (state_q == RUN) && (!s1_v_q || s2_load);
  assign in_fire  = in_valid && in_ready;

  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    assign ram_we[n] = load_we && ((load_addr_q >> IN_BITS) == AW'(n));

    lut_neuron_ram #(
      .WIDTH  (RAM_W),
      .ADDR_W (IN_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (ram_we[n]),
      .waddr (load_addr_q[IN_BITS-1:0]),
      .wdata (ram_wdata),
      .raddr (s1_data_q[n*IN_BITS +: IN_BITS]),
      .rdata (ram_rdata[n*RAM_W +: RAM_W])
    );

    assign s2_next[n*OUT_BITS +: OUT_BITS] = ram_rdata[n*RAM_W +: OUT_BITS];
`ifdef LUT_PARITY_EN
    assign par_bad[n] = ^ram_rdata[n*RAM_W +: RAM_W];
`endif
  end

  // Mode FSM and table loader; err is cleared whenever a fresh load begins.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    cfg_done_d  = 1'b0;
    err_d       = err_q;
    load_we     = 1'b0;
    case (state_q)
      UNCFG: begin
        if (cfg_start) begin
          state_d     = LOAD;
          load_addr_d = '0;
          err_d       = 1'b0;
        end
      end
      RUN: begin
        if (cfg_start) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_v_q && !s2_v_q) begin
          state_d     = LOAD;
          load_addr_d = '0;
          err_d       = 1'b0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          load_addr_d = '0;
          err_d       = 1'b0;
        end else if (cfg_valid) begin
          load_we     = 1'b1;
          load_addr_d = load_addr_q + AW'(1);
          if (load_addr_q == LAST_ADDR) begin
            state_d     = RUN;
            cfg_done_d  = 1'b1;
            load_addr_d = '0;
          end
        end
      end
      default: begin
        state_d = UNCFG;
      end
    endcase
`ifdef LUT_PARITY_EN
    if (s2_load && (|par_bad)) begin
      err_d = 1'b1;
    end
`endif
  end

  // Pipeline next-state: s1 captures accepted inputs, s2 captures table lookups.
  always_comb begin
    s1_v_d = s1_v_q;
    if (in_fire) begin
      s1_v_d = 1'b1;
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
    s1_data_d = in_fire ? in_data : s1_data_q;

    s2_v_d = s2_v_q;
    if (s2_load) begin
      s2_v_d = 1'b1;
    end else if (out_ready) begin
      s2_v_d = 1'b0;
    end
    s2_data_d = s2_load ? s2_next : s2_data_q;
  end

  // All control and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UNCFG;
      load_addr_q <= '0;
      cfg_done_q  <= 1'b0;
      err_q       <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_data_q   <= '0;
      s2_v_q      <= 1'b0;
      s2_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      cfg_done_q  <= cfg_done_d;
      err_q       <= err_d;
      s1_v_q      <= s1_v_d;
      s1_data_q   <= s1_data_d;
      s2_v_q      <= s2_v_d;
      s2_data_q   <= s2_data_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign cfg_done  = cfg_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lut_neuron_layer.sv
// Scoreboard bench for lut_neuron_layer (NEURONS=4, IN_BITS=8, OUT_BITS=1).
// Define LUT_PARITY_EN for both bench and RTL to exercise the parity path.
module tb_lut_neuron_layer;

  localparam int NEURONS  = 4;
  localparam int IN_BITS  = 8;
  localparam int OUT_BITS = 1;
  localparam int DEPTH_TB = 1 << IN_BITS;
  localparam int WORDS    = NEURONS * DEPTH_TB;
  localparam int NI       = NEURONS * IN_BITS;
  localparam int DW       = NEURONS * OUT_BITS;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [NI-1:0]       in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DW-1:0]       out_data;
  logic                cfg_start = 1'b0;
  logic                cfg_valid = 1'b0;
  logic [OUT_BITS-1:0] cfg_data = '0;
  logic                cfg_par = 1'b0;
  logic                cfg_done;
  logic                err;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t                sb[$];
  logic [OUT_BITS-1:0] modelTable [NEURONS][DEPTH_TB];
  int                  vectorsApplied = 0;
  int                  miscompares = 0;
  int                  cycle = 0;
  int                  delivered = 0;
  int                  doneCount = 0;
  int                  expectedDone = 0;
  bit                  latMode = 1'b0;
  bit                  holdValid = 1'b0;
  logic [DW-1:0]       holdData = '0;
  bit                  bpRun = 1'b0;

  lut_neuron_layer #(
    .NEURONS  (NEURONS),
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_par   (cfg_par),
    .cfg_done  (cfg_done),
    .err       (err)
  );

  // 10-unit clock; cycle counts rising edges.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Table contents: kind 0 is popcount(global address) > 4, kind 1 is address divisible by 3.
  function automatic logic [OUT_BITS-1:0] tableEntry(input int kind, input int a);
    logic [9:0] av;
    av = a[9:0];
    if (kind == 0) return OUT_BITS'(($countones(av) > 4) ? 1 : 0);
    return OUT_BITS'(((a % 3) == 0) ? 1 : 0);
  endfunction

  function automatic logic [DW-1:0] expectedOf(input logic [NI-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int n = 0; n < NEURONS; n++) begin
      r[n*OUT_BITS +: OUT_BITS] = modelTable[n][d[n*IN_BITS +: IN_BITS]];
    end
    return r;
  endfunction

  // Offer one word; queue its expected result when the handshake happens.
  task automatic applyStimulus(input logic [NI-1:0] d, input logic [DW-1:0] e);
    bit accepted;
    int offered;
    int waitCnt;
    accepted = 1'b0;
    waitCnt  = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!accepted) begin
      @(negedge clk);
      offered  = cycle;
      accepted = in_ready;
      if (latMode) checkOutput("full-rate in_ready", {31'd0, accepted}, 32'd1);
      @(posedge clk);
      if (accepted) sb.push_back('{data: e, cyc: offered, lat: latMode});
      #1;
      if (!accepted) begin
        waitCnt++;
        if (waitCnt > 200) begin
          checkOutput("in_ready timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic sendModel(input logic [NI-1:0] d);
    applyStimulus(d, expectedOf(d));
  endtask

  task automatic waitEmpty();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
      n++;
      if (n > 500) begin
        checkOutput("drain timeout", 32'(sb.size()), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Pulse cfg_start; from RUN, wait through DRAIN so the next edge is the first LOAD cycle.
  task automatic startLoad(input bit fromRun);
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    if (fromRun) waitEmpty();
  endtask

  task automatic loadTable(input int kind, input int nWords, input int badAddr);
    logic [OUT_BITS-1:0] v;
    int earlyDone;
    earlyDone = 0;
    for (int i = 0; i < nWords; i++) begin
      v         = tableEntry(kind, i);
      cfg_valid = 1'b1;
      cfg_data  = v;
      cfg_par   = (i == badAddr) ? ~(^v) : ^v;
      @(negedge clk);
      if (cfg_done) earlyDone++;
      @(posedge clk);
      modelTable[i / DEPTH_TB][i % DEPTH_TB] = v;
      #1;
    end
    cfg_valid = 1'b0;
    if (nWords == WORDS) begin
      expectedDone++;
      @(negedge clk);
      checkOutput("cfg_done after last write", {31'd0, cfg_done}, 32'd1);
      checkOutput("in_ready with cfg_done", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      checkOutput("cfg_done one cycle", {31'd0, cfg_done}, 32'd0);
      checkOutput("cfg_done early", 32'(earlyDone), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = '0;
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset out_data", 32'(out_data), 32'd0);
      checkOutput("reset err", {31'd0, err}, 32'd0);
      checkOutput("reset cfg_done", {31'd0, cfg_done}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: stall stability, occupancy limit and in-order result checking.
  always @(negedge clk) begin
    exp_t item;
    if (cfg_done) doneCount++;
    if (rst) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid && out_valid) checkOutput("stall stability", 32'(out_data), 32'(holdData));
      if (sb.size() >= 2 && !out_ready) checkOutput("in_ready when full", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected output", 32'd1, 32'd0);
        end else begin
          item = sb.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(item.data));
          if (item.lat) checkOutput("latency", 32'(cycle - item.cyc), 32'd2);
          delivered++;
        end
      end
      holdValid = out_valid && !out_ready;
      holdData  = out_data;
    end
  end

  initial begin
    #2000000;
    checkOutput("watchdog", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

  initial begin
    logic [NI-1:0] d;
    logic [3:0]    bpPat;
    int            base;

    doReset();
    out_ready = 1'b1;

    // First load, hand-computed directed words, then a full-rate random stream.
    startLoad(1'b0);
    loadTable(0, WORDS, -1);
    applyStimulus({8'hFF, 8'h1F, 8'h0F, 8'h00}, 4'b1110);
    applyStimulus({8'h00, 8'h07, 8'hF0, 8'h1F}, 4'b0011);
    latMode = 1'b1;
    repeat (256) begin
      d = NI'($urandom);
      sendModel(d);
    end
    latMode = 1'b0;
    waitEmpty();

    // Backpressure: out_ready follows 1,0,0,1 while 24 words stream in.
    base  = delivered;
    bpPat = 4'b1001;
    bpRun = 1'b1;
    fork
      begin
        repeat (24) begin
          d = NI'($urandom);
          sendModel(d);
        end
        bpRun = 1'b0;
      end
      begin
        int idx;
        idx = 0;
        while (bpRun) begin
          @(posedge clk);
          #1;
          out_ready = bpPat[idx % 4];
          idx++;
        end
      end
    join
    out_ready = 1'b1;
    waitEmpty();
    checkOutput("backpressure delivered", 32'(delivered - base), 32'd24);

    // Reload with two words in flight and the output stalled.
    out_ready = 1'b0;
    applyStimulus({8'hFF, 8'h1F, 8'h0F, 8'h00}, 4'b1110);
    applyStimulus({8'h00, 8'h07, 8'hF0, 8'h1F}, 4'b0011);
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("drain in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("drain out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitEmpty();
    loadTable(1, WORDS, -1);
    applyStimulus({NI{1'b0}}, 4'b1001);
    repeat (4) begin
      d = NI'($urandom);
      sendModel(d);
    end
    waitEmpty();

    // Reset part-way through a load, then a complete load must work.
    startLoad(1'b1);
    loadTable(0, 300, -1);
    doReset();
    out_ready = 1'b1;
    startLoad(1'b0);
    loadTable(0, WORDS, -1);
    applyStimulus({8'h00, 8'h07, 8'hF0, 8'h1F}, 4'b0011);
    latMode = 1'b1;
    repeat (16) begin
      d = NI'($urandom);
      sendModel(d);
    end
    latMode = 1'b0;
    waitEmpty();

`ifdef LUT_PARITY_EN
    // Corrupt parity on neuron 2 entry 5 and look that entry up.
    startLoad(1'b1);
    loadTable(0, WORDS, 2 * DEPTH_TB + 5);
    checkOutput("err before lookup", {31'd0, err}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h0005_0000;
    @(negedge clk);
    checkOutput("parity in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back('{data: 4'b0000, cyc: cycle, lat: 1'b0});
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("err in s1", {31'd0, err}, 32'd0);
    checkOutput("out_valid in s1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("out_valid with err", {31'd0, out_valid}, 32'd1);
    checkOutput("err rises", {31'd0, err}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("err sticky", {31'd0, err}, 32'd1);
    end
    @(posedge clk);
    #1;
    startLoad(1'b1);
    @(negedge clk);
    checkOutput("err cleared in LOAD", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    loadTable(0, WORDS, -1);
`else
    checkOutput("err stays low", {31'd0, err}, 32'd0);
`endif

    checkOutput("cfg_done pulse count", 32'(doneCount), 32'(expectedDone));
    checkOutput("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
